crc8_frame_checker: RTL and testbench
=====================================

# crc8_frame_checker

Serial frame receiver and checker for the CRC-8 bit-serial link. It is the receive-side counterpart of the team's CRC-8 generator. It accepts a START-delimited bitstream of PAYLOAD_BYTES payload bytes followed by the 8-bit CRC, MSB first. It runs every bit through the same CRC-8 shift register (polynomial x^8+x^2+x+1, i.e. 0x07, init 0x00, no final XOR) and reports a pass/fail verdict with the captured payload. It sits between the bit-level deserializer/strobe logic and the frame consumer.

## Interface
- PAYLOAD_BYTES, default 4: payload length in bytes, range 1..16.
- CLK  input  1  single system clock; all state changes on its rising edge.
- RESET  input  1  synchronous reset, active-high.
- START  input  1  single-cycle pulse; begins a new frame and aborts any frame in progress.
- BITVAL  input  1  serial data bit.
- BITEN  input  1  qualifies BITVAL; one bit is consumed per cycle in which it is high.
- BUSY  output  1  high while a frame is being received.
- PAYLOAD  output  8*PAYLOAD_BYTES  captured payload; the first received bit lands in the MSB.
- DONE  output  1  one-cycle pulse at the end of a frame.
- CRC_OK  output  1  verdict: remainder equals 0x00. Valid from DONE until the next START or RESET.
- CRC  output  8  running CRC register, for debug.
- ERR_CNT  output  8  count of failed frames, saturating at 0xFF.

## Operation
- States:
  - IDLE: no frame in progress.
  - RX: receiving payload bits, then the received CRC byte (FRAME_BITS = 8*PAYLOAD_BYTES+8 bits in total).
  - DONE: one-cycle verdict state.
- CRC update per consumed bit: inv = BITVAL ^ CRC[7]; CRC <= {CRC[6:3], CRC[2], CRC[1]^inv, CRC[0]^inv, inv}.
  - In other words, CRC[7:3] <= CRC[6:2], CRC[2] <= CRC[1]^inv, CRC[1] <= CRC[0]^inv, CRC[0] <= inv.
  - This is bit-identical to the generator's update.
- Check method: payload and received CRC byte pass through the same register. A correct frame leaves remainder 0x00.
- Bit counter: wide enough to hold FRAME_BITS. Reset to 0 on START. Increments on each consumed bit.
- The first 8*PAYLOAD_BYTES consumed bits shift into PAYLOAD from the LSB side (shift left), so the first bit received ends up as PAYLOAD's MSB.
- The received CRC byte is not stored. Only the remainder is kept.
- Transitions:
  - IDLE -> RX on START. Clears CRC to 0x00, clears the counter, clears CRC_OK.
  - RX -> DONE when the bit with counter == FRAME_BITS-1 is consumed.
  - RX -> RX on START (restart). The aborted frame is not counted or reported.
  - DONE -> IDLE unconditionally, unless START is high, in which case DONE -> RX.
- Action in DONE:
  - CRC_OK <= (CRC == 8'h00).
  - If the remainder is not 0x00, ERR_CNT increments unless already 0xFF.
- BITEN in IDLE or DONE: ignored. CRC and PAYLOAD hold.
- START and BITEN high in the same cycle: START wins and that bit is not consumed.
- Gaps (BITEN low) inside RX: state holds indefinitely. No timeout.
- RESET (any state, mid-frame included):
  - State -> IDLE.
  - BUSY=0, DONE=0, CRC_OK=0, CRC=0x00, PAYLOAD=0, ERR_CNT=0, counter=0.

## Timing
- All outputs are registered.
- BUSY rises the cycle after START is sampled. It stays high through RX and falls in the DONE cycle.
- Latency:
  - DONE is high exactly one cycle, the cycle after the last CRC bit is sampled.
  - CRC_OK updates at the same edge as DONE asserts.
  - ERR_CNT updates on the edge after DONE.
- Minimum frame duration: FRAME_BITS cycles with BITEN held high, plus 1 cycle for START.
- Back-to-back frames: a START coincident with the DONE cycle is accepted with no idle cycle needed.
- PAYLOAD is stable from the DONE cycle until the next START.

## Test plan
- Default N=4, START then 40 bits of payload 0x00000001 + CRC 0x07, BITEN continuous -> DONE pulse after bit 40, CRC_OK=1, PAYLOAD=0x00000001, CRC=0x00, ERR_CNT=0.
- Same frame with CRC byte 0x06 -> CRC_OK=0, CRC remainder 0x07, ERR_CNT=1.
- N=1: payload 0x80 + CRC 0x89 -> CRC_OK=1. Payload 0x01 + CRC 0x07, sent with a random BITEN gap pattern (up to 5 idle cycles between bits) -> CRC_OK=1, same DONE count.
- START after 20 bits of a frame, then a full valid frame -> exactly one DONE, CRC_OK=1, ERR_CNT unchanged. START+BITEN in the same cycle -> that bit is not counted (the frame still needs 40 further bits).
- RESET asserted mid-frame at bit 17 -> next cycle all outputs 0, state IDLE. BITEN pulses without START -> no DONE, CRC stays 0x00.
- 256 consecutive bad frames, back-to-back START coincident with DONE -> ERR_CNT saturates at 0xFF. A good frame afterwards leaves it at 0xFF with CRC_OK=1.

Source files
------------

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 (poly 0x07, init 0x00) frame checker: captures PAYLOAD_BYTES of
// MSB-first payload, runs payload and received CRC byte through one register, flags remainder 0.
module crc8_frame_checker #(
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic                       BITVAL,
  input  logic                       BITEN,
  output logic                       BUSY,
  output logic [8*PAYLOAD_BYTES-1:0] PAYLOAD,
  output logic                       DONE,
  output logic                       CRC_OK,
  output logic [7:0]                 CRC,
  output logic [7:0]                 ERR_CNT,
  output logic [1:0]                 STATE_DBG
);

  localparam int PB = 8 * PAYLOAD_BYTES;
  localparam int FB = PB + 8;
  localparam int CW = $clog2(FB + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RX   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [7:0]      crc_q;
  logic [7:0]      crc_d;
  logic [CW-1:0]   cnt_q;
  logic [PB-1:0]   payload_q;
  logic [PB-1:0]   payload_d;
  logic            busy_q;
  logic            done_q;
  logic            crc_ok_q;
  logic [7:0]      err_cnt_q;
  logic            inv;
  logic            last_bit;

  // Same shift/feedback as the transmit-side generator, one bit per consumed BITVAL.
  assign inv       = BITVAL ^ crc_q[7];
  assign crc_d     = {crc_q[6:2], crc_q[1] ^ inv, crc_q[0] ^ inv, inv};
  assign payload_d = {payload_q[PB-2:0], BITVAL};
  assign last_bit  = (cnt_q == CW'(FB - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      crc_q     <= 8'h00;
      cnt_q     <= '0;
      payload_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_q  <= S_RX;
            busy_q   <= 1'b1;
            crc_q    <= 8'h00;
            cnt_q    <= '0;
            crc_ok_q <= 1'b0;
          end
        end
        S_RX: begin
          // START takes priority over a coincident bit, which is dropped.
          if (START) begin
            crc_q    <= 8'h00;
            cnt_q    <= '0;
            crc_ok_q <= 1'b0;
          end else if (BITEN) begin
            crc_q <= crc_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q < CW'(PB)) payload_q <= payload_d;
            if (last_bit) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              crc_ok_q <= (crc_d == 8'h00);
            end
          end
        end
        S_DONE: begin
          // The frame is tallied here even when a new START arrives this cycle.
          if (crc_q != 8'h00 && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          if (START) begin
            state_q  <= S_RX;
            busy_q   <= 1'b1;
            crc_q    <= 8'h00;
            cnt_q    <= '0;
            crc_ok_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign PAYLOAD   = payload_q;
  assign DONE      = done_q;
  assign CRC_OK    = crc_ok_q;
  assign CRC       = crc_q;
  assign ERR_CNT   = err_cnt_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed bench for crc8_frame_checker: one 4-byte and one 1-byte instance, hand-computed CRCs.
module tb_crc8_frame_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, bv4, en4, start1, bv1, en1;
  logic        busy4, done4, ok4, busy1, done1, ok1;
  logic [31:0] pay4;
  logic [7:0]  pay1, crc4, crc1, err4, err1;
  logic [1:0]  st4, st1;
  int          compared = 0;
  int          mismatched = 0;
  int          done_cnt4 = 0;
  int          done_cnt1 = 0;
  int          d0;

  always #5 clk = ~clk;

  crc8_frame_checker #(.PAYLOAD_BYTES(4)) dut4 (
    .CLK(clk), .RESET(rst), .START(start4), .BITVAL(bv4), .BITEN(en4),
    .BUSY(busy4), .PAYLOAD(pay4), .DONE(done4), .CRC_OK(ok4), .CRC(crc4),
    .ERR_CNT(err4), .STATE_DBG(st4)
  );

  crc8_frame_checker #(.PAYLOAD_BYTES(1)) dut1 (
    .CLK(clk), .RESET(rst), .START(start1), .BITVAL(bv1), .BITEN(en1),
    .BUSY(busy1), .PAYLOAD(pay1), .DONE(done1), .CRC_OK(ok1), .CRC(crc1),
    .ERR_CNT(err1), .STATE_DBG(st1)
  );

  always @(negedge clk) begin
    if (done4 === 1'b1) done_cnt4++;
    if (done1 === 1'b1) done_cnt1++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic s, input logic e, input logic v);
    if (sel) begin
      start1 = s; en1 = e; bv1 = v;
    end else begin
      start4 = s; en4 = e; bv4 = v;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? done1 : done4;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy4;
  endfunction

  // START pulse, then payload + CRC byte MSB first with optional random gaps.
  // Returns in the DONE cycle without advancing the clock further.
  task automatic send_frame(input bit sel, input logic [31:0] pay, input logic [7:0] crcb,
                            input int gap_max, input bit start_with_bit, input string tag);
    int   nb;
    int   g;
    logic b;
    bit   early;
    nb    = sel ? 8 : 32;
    early = 1'b0;
    drive(sel, 1'b1, start_with_bit, 1'b1);
    tick;
    drive(sel, 1'b0, 1'b0, 1'b0);
    chk({tag, "_busy_rise"}, {31'd0, get_busy(sel)}, 32'd1);
    for (int i = 0; i < nb + 8; i++) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) tick;
      b = (i < nb) ? pay[nb-1-i] : crcb[7-(i-nb)];
      drive(sel, 1'b0, 1'b1, b);
      tick;
      drive(sel, 1'b0, 1'b0, 1'b0);
      if (i < nb + 7 && get_done(sel) === 1'b1) early = 1'b1;
    end
    chk({tag, "_early_done"}, {31'd0, early}, 32'd0);
    chk({tag, "_done"}, {31'd0, get_done(sel)}, 32'd1);
    chk({tag, "_busy_fall"}, {31'd0, get_busy(sel)}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick;
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_done", {31'd0, done4}, 32'd0);
    chk("rst_ok", {31'd0, ok4}, 32'd0);
    chk("rst_crc", {24'd0, crc4}, 32'd0);
    chk("rst_err", {24'd0, err4}, 32'd0);
    chk("rst_payload", pay4, 32'd0);
    chk("rst_state", {30'd0, st4}, 32'd0);
    rst = 1'b0;
    tick;

    // Good frame 0x00000001 / 0x07
    send_frame(1'b0, 32'h0000_0001, 8'h07, 0, 1'b0, "t1");
    chk("t1_ok", {31'd0, ok4}, 32'd1);
    chk("t1_payload", pay4, 32'h0000_0001);
    chk("t1_crc", {24'd0, crc4}, 32'd0);
    chk("t1_state_done", {30'd0, st4}, 32'd2);
    tick;
    chk("t1_done_fall", {31'd0, done4}, 32'd0);
    chk("t1_err", {24'd0, err4}, 32'd0);
    chk("t1_state_idle", {30'd0, st4}, 32'd0);
    chk("t1_done_cnt", done_cnt4, 32'd1);

    // Bad CRC byte: remainder table[0x01] = 0x07
    send_frame(1'b0, 32'h0000_0001, 8'h06, 0, 1'b0, "t2");
    chk("t2_ok", {31'd0, ok4}, 32'd0);
    chk("t2_crc", {24'd0, crc4}, 32'h07);
    chk("t2_err_not_yet", {24'd0, err4}, 32'd0);
    tick;
    chk("t2_err", {24'd0, err4}, 32'd1);

    // More good frames: CRC(00 00 00 80)=0x89, CRC(01 00 00 00)=0x16
    send_frame(1'b0, 32'h0000_0080, 8'h89, 0, 1'b0, "t3a");
    chk("t3a_ok", {31'd0, ok4}, 32'd1);
    chk("t3a_payload", pay4, 32'h0000_0080);
    tick;
    send_frame(1'b0, 32'h0100_0000, 8'h16, 0, 1'b0, "t3b");
    chk("t3b_ok", {31'd0, ok4}, 32'd1);
    chk("t3b_crc", {24'd0, crc4}, 32'd0);
    chk("t3b_payload", pay4, 32'h0100_0000);
    tick;
    chk("t3b_err", {24'd0, err4}, 32'd1);

    // One-byte instance, contiguous then gapped
    send_frame(1'b1, 32'h80, 8'h89, 0, 1'b0, "n1a");
    chk("n1a_ok", {31'd0, ok1}, 32'd1);
    chk("n1a_payload", {24'd0, pay1}, 32'h80);
    tick;
    send_frame(1'b1, 32'h01, 8'h07, 5, 1'b0, "n1b");
    chk("n1b_ok", {31'd0, ok1}, 32'd1);
    chk("n1b_payload", {24'd0, pay1}, 32'h01);
    tick;
    chk("n1_done_cnt", done_cnt1, 32'd2);
    chk("n1_err", {24'd0, err1}, 32'd0);

    // Abort after 20 bits, then a full valid frame
    d0 = done_cnt4;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      tick;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 32'h0000_0080, 8'h89, 0, 1'b0, "t5");
    chk("t5_ok", {31'd0, ok4}, 32'd1);
    tick;
    chk("t5_one_done", done_cnt4 - d0, 32'd1);
    chk("t5_err", {24'd0, err4}, 32'd1);

    // START with BITEN: that bit must not count
    send_frame(1'b0, 32'h0000_0001, 8'h07, 0, 1'b1, "t6");
    chk("t6_ok", {31'd0, ok4}, 32'd1);
    chk("t6_payload", pay4, 32'h0000_0001);
    tick;

    // Reset mid-frame at bit 17
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b0, 1'b1, i[0]);
      tick;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mr_busy", {31'd0, busy4}, 32'd0);
    chk("mr_done", {31'd0, done4}, 32'd0);
    chk("mr_ok", {31'd0, ok4}, 32'd0);
    chk("mr_crc", {24'd0, crc4}, 32'd0);
    chk("mr_payload", pay4, 32'd0);
    chk("mr_err", {24'd0, err4}, 32'd0);
    chk("mr_state", {30'd0, st4}, 32'd0);
    d0 = done_cnt4;
    for (int i = 0; i < 45; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      tick;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    chk("nostart_done", done_cnt4 - d0, 32'd0);
    chk("nostart_crc", {24'd0, crc4}, 32'd0);
    chk("nostart_payload", pay4, 32'd0);
    chk("nostart_busy", {31'd0, busy4}, 32'd0);

    // 256 bad frames back to back, START in each DONE cycle
    d0 = done_cnt4;
    for (int f = 0; f < 256; f++) begin
      send_frame(1'b0, 32'h0000_0001, 8'h06, 0, 1'b0, "sat");
    end
    tick;
    chk("sat_err", {24'd0, err4}, 32'hFF);
    chk("sat_done_cnt", done_cnt4 - d0, 32'd256);
    send_frame(1'b0, 32'h0000_0001, 8'h07, 0, 1'b0, "sat_good");
    chk("sat_good_ok", {31'd0, ok4}, 32'd1);
    tick;
    chk("sat_good_err", {24'd0, err4}, 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
